// File: rtl/serial_adder_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : serial_adder_ctrl_if
// Brief   : Request/result bundle between a requester and serial_adder_ctrl.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// Module  : serial_adder_ctrl
// Brief   : Bit-serial WIDTH-bit adder reusing one full-adder slice, LSB first.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [c_CW-1:0]  r_cnt;

  logic             w_sbit;
  logic             w_cbit;
  logic             w_last;
  logic             w_accept;
  logic             w_run;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = w_run && (r_cnt == c_LAST);

  // The single shared full-adder slice.
  assign w_sbit = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cbit = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.carry_in;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_cbit;
      r_sum   <= {w_sbit, r_sum[WIDTH-1:1]};
      // Counter parks on the last index rather than wrapping.
      if (w_last) begin
        r_cout <= w_cbit;
      end else begin
        r_cnt  <= r_cnt + c_ONE;
      end
    end
  end

  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_cout;

endmodule

`default_nettype wire
